shift_rotate_unit: RTL and testbench

Parametrised multi-step shift/rotate register and the successor to the fixed 6-bit single-step rotator. It loads a WIDTH-bit word, then on a start command performs an N-step rotate or shift in one direction, one bit position per clock. It reports progress with busy and done. It is the data-path shifter used by the lab experiment benches and by later serial-link blocks.

---
 rtl/shift_rotate_pkg.sv | 46 ++++
 rtl/shift_rotate_unit.sv | 96 +++++++++
 tb/tb_shift_rotate_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/shift_rotate_pkg.sv
// Shared encodings and the single-step shift/rotate function for shift_rotate_unit.
// The step function works on a fixed maximum-width word; callers pass their MSB index.
package shift_rotate_pkg;

    localparam int STEP_MAX_W = 64;
    localparam int STEP_IDX_W = 6;

    typedef enum logic [1:0] {
        ROR = 2'b00,
        ROL = 2'b01,
        SHR = 2'b10,
        SHL = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Returns {ser_out, next_data}; bits above msb are forced to zero.
    function automatic logic [STEP_MAX_W:0] step_word(
        input logic [STEP_MAX_W-1:0] d,
        input logic [STEP_IDX_W-1:0] msb,
        input mode_e                 mode,
        input logic                  ser_in
    );
        logic [STEP_MAX_W-1:0] mask;
        logic [STEP_MAX_W-1:0] dm;
        logic [STEP_MAX_W-1:0] nd;
        logic                  so;
        mask = {STEP_MAX_W{1'b1}} >> (STEP_IDX_W'(STEP_MAX_W - 1) - msb);
        dm   = d & mask;
        nd   = dm;
        so   = 1'b0;
        case (mode)
            ROR: begin nd = dm >> 1;          nd[msb] = dm[0];  so = dm[0];   end
            ROL: begin nd = (dm << 1) & mask; nd[0]   = dm[msb]; so = dm[msb]; end
            SHR: begin nd = dm >> 1;          nd[msb] = ser_in; so = dm[0];   end
            SHL: begin nd = (dm << 1) & mask; nd[0]   = ser_in; so = dm[msb]; end
            default: ;
        endcase
        return {so, nd};
    endfunction

endpackage

// File: rtl/shift_rotate_unit.sv
// Multi-step shift/rotate register: load a word, then rotate or shift it one bit
// per clock for a captured step count, reporting progress on busy and done.
module shift_rotate_unit
    import shift_rotate_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic             ser_in,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    state_e                state;
    mode_e                 mode_q;
    logic [AMT_W-1:0]      remaining;
    logic                  zero_pend;
    logic [WIDTH-1:0]      data_q;
    logic                  ser_q;
    logic                  busy_q;
    logic                  done_q;
    logic [STEP_MAX_W:0]   step_r;

    // WIDTH must not exceed STEP_MAX_W; the step is computed on a zero-extended word.
    always_comb begin
        step_r = step_word(STEP_MAX_W'(data_q), STEP_IDX_W'(WIDTH - 1), mode_q, ser_in);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= ROR;
            remaining <= '0;
            zero_pend <= 1'b0;
            data_q    <= '0;
            ser_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (load) begin
                        data_q <= load_data;
                    end else if (start) begin
                        mode_q    <= mode_e'(mode);
                        remaining <= amount;
                        if (amount == '0) begin
                            state     <= DONE;
                            zero_pend <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    data_q    <= step_r[WIDTH-1:0];
                    ser_q     <= step_r[STEP_MAX_W];
                    remaining <= remaining - 1'b1;
                    if (remaining == AMT_W'(1)) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    // A zero-step start spends one extra cycle here so done lands one edge later.
                    if (zero_pend) begin
                        zero_pend <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        done_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign data_out = data_q;
    assign ser_out  = ser_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Directed bench for shift_rotate_unit with WIDTH=10, AMT_W=4.
module tb_shift_rotate_unit;

    localparam int WIDTH = 10;
    localparam int AMT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             start;
    logic [1:0]       mode;
    logic [AMT_W-1:0] amount;
    logic             ser_in;
    logic [WIDTH-1:0] data_out;
    logic             ser_out;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [WIDTH-1:0] WORD  = 10'b1101100101;
    localparam logic [WIDTH-1:0] WORD2 = 10'b0011110000;

    shift_rotate_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .load_data(load_data),
        .start(start), .mode(mode), .amount(amount), .ser_in(ser_in),
        .data_out(data_out), .ser_out(ser_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] w);
        load = 1'b1; load_data = w;
        tick();
        load = 1'b0;
    endtask

    task automatic start_op(input logic [1:0] m, input logic [AMT_W-1:0] a);
        start = 1'b1; mode = m; amount = a;
        tick();
        start = 1'b0; mode = 2'b00; amount = '0;
    endtask

    // Samples after each edge following the start edge; sample c is after edge k+c.
    task automatic measure(output int busy_n, output int done_n, output int done_at,
                           output int overlap);
        busy_n = 0; done_n = 0; done_at = -1; overlap = 0;
        for (int c = 0; c < 40; c++) begin
            if (busy) busy_n++;
            if (done) begin done_n++; done_at = c; end
            if (busy && done) overlap++;
            if (!busy && !done && c > 0 && done_n > 0) break;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; load_data = '0; start = 1'b0;
        mode = 2'b00; amount = '0; ser_in = 1'b0;
        tick(); tick();
        n_checks++;
        if ({data_out, ser_out, busy, done} !== 13'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b, want 0", {data_out, ser_out, busy, done});
        end
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ror1();
        int b, d, da, ov;
        do_load(WORD);
        n_checks++;
        if (data_out !== WORD) begin
            n_fail++; $display("FAIL load_latency: got %b, want %b", data_out, WORD);
        end
        start_op(2'b00, 4'd1);
        measure(b, d, da, ov);
        n_checks++;
        if (data_out !== 10'b1110110010 || ser_out !== 1'b1) begin
            n_fail++; $display("FAIL ror1_data: got %b/%b, want 1110110010/1", data_out, ser_out);
        end
        n_checks++;
        if (b != 1 || d != 1 || da != 1 || ov != 0) begin
            n_fail++; $display("FAIL ror1_timing: busy=%0d done=%0d at=%0d ov=%0d, want 1 1 1 0", b, d, da, ov);
        end
    endtask

    task automatic test_rol3();
        int b, d, da, ov;
        do_load(WORD);
        start_op(2'b01, 4'd3);
        measure(b, d, da, ov);
        n_checks++;
        if (data_out !== 10'b1100101110 || ser_out !== 1'b0) begin
            n_fail++; $display("FAIL rol3_data: got %b/%b, want 1100101110/0", data_out, ser_out);
        end
        n_checks++;
        if (b != 3 || d != 1 || da != 3 || ov != 0) begin
            n_fail++; $display("FAIL rol3_timing: busy=%0d done=%0d at=%0d ov=%0d, want 3 1 3 0", b, d, da, ov);
        end
    endtask

    task automatic test_shr4();
        int b, d, da, ov;
        do_load(WORD);
        ser_in = 1'b1;
        start_op(2'b10, 4'd4);
        measure(b, d, da, ov);
        ser_in = 1'b0;
        n_checks++;
        if (data_out !== 10'b1111110110 || ser_out !== 1'b0) begin
            n_fail++; $display("FAIL shr4_data: got %b/%b, want 1111110110/0", data_out, ser_out);
        end
        n_checks++;
        if (b != 4 || da != 4) begin
            n_fail++; $display("FAIL shr4_timing: busy=%0d at=%0d, want 4 4", b, da);
        end
    endtask

    task automatic test_wrap_and_zero();
        int b, d, da, ov;
        do_load(WORD);
        start_op(2'b00, 4'd10);
        measure(b, d, da, ov);
        n_checks++;
        if (data_out !== WORD || ser_out !== 1'b1) begin
            n_fail++; $display("FAIL ror10_data: got %b/%b, want %b/1", data_out, ser_out, WORD);
        end
        n_checks++;
        if (b != 10 || d != 1 || da != 10 || ov != 0) begin
            n_fail++; $display("FAIL ror10_timing: busy=%0d done=%0d at=%0d ov=%0d, want 10 1 10 0", b, d, da, ov);
        end
        start_op(2'b01, 4'd0);
        measure(b, d, da, ov);
        n_checks++;
        if (b != 0 || d != 1 || da != 1) begin
            n_fail++; $display("FAIL zero_amount_timing: busy=%0d done=%0d at=%0d, want 0 1 1", b, d, da);
        end
        n_checks++;
        if (data_out !== WORD) begin
            n_fail++; $display("FAIL zero_amount_data: got %b, want %b", data_out, WORD);
        end
    endtask

    task automatic test_ignored_cmds();
        int bsum, dsum;
        bsum = 0; dsum = 0;
        load = 1'b1; load_data = WORD2; start = 1'b1; mode = 2'b00; amount = 4'd5;
        tick();
        load = 1'b0; start = 1'b0; amount = '0;
        for (int c = 0; c < 4; c++) begin
            if (busy) bsum++;
            if (done) dsum++;
            tick();
        end
        n_checks++;
        if (data_out !== WORD2 || bsum != 0 || dsum != 0) begin
            n_fail++; $display("FAIL load_beats_start: data=%b busy=%0d done=%0d, want %b 0 0", data_out, bsum, dsum, WORD2);
        end
        bsum = 0; dsum = 0;
        start_op(2'b01, 4'd3);
        for (int c = 0; c < 20; c++) begin
            if (c == 1) begin start = 1'b1; mode = 2'b00; amount = 4'd7; end
            if (c == 2) begin start = 1'b0; amount = '0; end
            if (busy) bsum++;
            if (done) dsum++;
            if (!busy && !done && dsum > 0) break;
            tick();
        end
        n_checks++;
        if (bsum != 3 || dsum != 1 || data_out !== 10'b1110000001) begin
            n_fail++; $display("FAIL start_in_run: busy=%0d done=%0d data=%b, want 3 1 1110000001", bsum, dsum, data_out);
        end
    endtask

    task automatic test_reset_mid_op();
        int b, d, da, ov;
        int dsum;
        dsum = 0;
        do_load(WORD);
        start_op(2'b11, 4'd5);
        tick(); tick();
        n_checks++;
        if (data_out !== 10'b0110010100 || busy !== 1'b1) begin
            n_fail++; $display("FAIL shl_two_steps: got %b busy=%b, want 0110010100 1", data_out, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({data_out, ser_out, busy, done} !== 13'b0) begin
            n_fail++; $display("FAIL async_reset: got %b, want 0", {data_out, ser_out, busy, done});
        end
        for (int c = 0; c < 8; c++) begin
            if (done) dsum++;
            tick();
        end
        n_checks++;
        if (dsum != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_done: done=%0d busy=%b, want 0 0", dsum, busy);
        end
        #3 rst_n = 1'b1;
        tick();
        do_load(WORD);
        start_op(2'b00, 4'd1);
        measure(b, d, da, ov);
        n_checks++;
        if (data_out !== 10'b1110110010 || ser_out !== 1'b1 || b != 1 || da != 1) begin
            n_fail++; $display("FAIL post_reset_ror1: got %b/%b busy=%0d at=%0d, want 1110110010/1 1 1", data_out, ser_out, b, da);
        end
    endtask

    initial begin
        test_reset();
        test_ror1();
        test_rol3();
        test_shr4();
        test_wrap_and_zero();
        test_ignored_cmds();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
